// File: rtl/dram_throttle_pkg.sv
// Shared definitions for the DRAM channel throttle: mode encodings, LFSR
// polynomial, percent scale and the LFSR/percent helper functions.
package dram_throttle_pkg;

  typedef enum logic [1:0] {
    THR_BYPASS = 2'b00,
    THR_LAT    = 2'b01,
    THR_LATBW  = 2'b10
  } thr_mode_e;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam int unsigned PCT_SCALE = 100;

  // Right-shifting Galois step.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  // Maps the low 7 LFSR bits onto 0..99.
  function automatic logic [6:0] lfsr_pct(input logic [15:0] s);
    logic [13:0] prod;
    prod = 14'(s[6:0]) * 14'(PCT_SCALE);
    return prod[13:7];
  endfunction

endpackage

// File: rtl/lfsr_percent.sv
// Free-running 16-bit Galois LFSR producing a 0..99 pseudo-random percent and
// a stall flag when that value reaches the requested duty.
//   i_clock   : system clock
//   i_reset   : asynchronous active-high reset (loads Seed)
//   i_percent : duty in percent; >=100 never stalls, 0 always stalls
//   o_stall   : o_rand >= i_percent
//   o_rand    : current pseudo-random percent, 0..99
module lfsr_percent #(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [6:0] i_percent,
  output logic       o_stall,
  output logic [6:0] o_rand
);
  import dram_throttle_pkg::*;

  logic [15:0] r_lfsr;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_lfsr <= Seed;
    else         r_lfsr <= lfsr_step(r_lfsr);
  end

  assign o_rand  = lfsr_pct(r_lfsr);
  assign o_stall = (o_rand >= i_percent);

endmodule

// File: rtl/dram_throttle_channel.sv
// Deterministic latency/bandwidth throttle for one valid/ready DRAM channel.
// Beats are buffered in order, each held for a minimum latency, and both the
// accept and issue sides are duty-cycle gated by independent LFSRs.
//   i_clock/i_reset            : clock, asynchronous active-high reset
//   i_mode                     : 00 bypass, 01 latency, 10/11 latency+bandwidth
//   i_in_bandwidth/i_out_bandwidth : accept / issue duty in percent
//   i_latency                  : minimum cycles from accept to first o_out_valid
//   i_in_data/i_in_valid/o_in_ready   : upstream beat handshake
//   o_out_data/o_out_valid/i_out_ready: downstream beat handshake
//   o_occupancy                : stored beat count
//   o_stall_count              : saturating count of ripe-head cycles lost to issue stall
module dram_throttle_channel #(
  parameter int unsigned Width    = 64,
  parameter int unsigned Depth    = 16,
  parameter int unsigned LatWidth = 6,
  parameter logic [15:0] SeedIn   = 16'hACE1,
  parameter logic [15:0] SeedOut  = 16'h1D87,
  parameter int unsigned CntWidth = 32
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [1:0]               i_mode,
  input  logic [6:0]               i_in_bandwidth,
  input  logic [6:0]               i_out_bandwidth,
  input  logic [LatWidth-1:0]      i_latency,
  input  logic [Width-1:0]         i_in_data,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  output logic [Width-1:0]         o_out_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [$clog2(Depth):0]   o_occupancy,
  output logic [CntWidth-1:0]      o_stall_count
);
  import dram_throttle_pkg::*;

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned TW = LatWidth + 1;

  logic [Width-1:0]    r_data  [Depth];
  logic [TW-1:0]       r_stamp [Depth];
  logic [Depth-1:0]    r_ripe;
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_count;
  logic [TW-1:0]       r_now;
  logic [CntWidth-1:0] r_stall_cnt;

  logic                w_in_stall_raw;
  logic                w_out_stall_raw;
  logic [6:0]          w_in_rand;
  logic [6:0]          w_out_rand;
  logic                w_unused;
  logic                w_bw_en;
  logic                w_in_stall;
  logic                w_out_stall;
  logic                w_full;
  logic                w_empty;
  logic                w_head_ripe;
  logic                w_push;
  logic                w_pop;
  logic [TW-1:0]       w_eff_lat;
  logic [Depth-1:0]    w_ripe_now;
  logic [Depth-1:0]    w_ripe_next;

  lfsr_percent #(.Seed(SeedIn)) u_lfsr_in (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_percent (i_in_bandwidth),
    .o_stall   (w_in_stall_raw),
    .o_rand    (w_in_rand)
  );

  lfsr_percent #(.Seed(SeedOut)) u_lfsr_out (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_percent (i_out_bandwidth),
    .o_stall   (w_out_stall_raw),
    .o_rand    (w_out_rand)
  );

  assign w_unused = ^{w_in_rand, w_out_rand};

  // THR_LATBW and the reserved 11 encoding both carry bit 1.
  assign w_bw_en     = i_mode[1];
  assign w_in_stall  = w_bw_en && w_in_stall_raw;
  assign w_out_stall = w_bw_en && w_out_stall_raw;

  always_comb begin
    if (i_mode == 2'(THR_BYPASS) || i_latency == '0) w_eff_lat = TW'(1);
    else                                             w_eff_lat = {1'b0, i_latency};
  end

  // Age uses modular subtraction on the wrapping timestamp; the ripe bit is
  // sticky so an entry that ripened stays ripe after the age wraps. The live
  // comparison makes a beat visible in the same cycle its age reaches EffLat.
  for (genvar g = 0; g < Depth; g++) begin : g_slot
    logic [AW-1:0] w_off;
    logic [TW-1:0] w_age;
    assign w_off         = AW'(g) - r_rd_ptr;
    assign w_age         = r_now - r_stamp[g];
    assign w_ripe_now[g] = r_ripe[g] | (({1'b0, w_off} < r_count) && (w_age >= w_eff_lat));
  end

  assign w_full      = (r_count == (AW+1)'(Depth));
  assign w_empty     = (r_count == '0);
  assign w_head_ripe = w_ripe_now[r_rd_ptr];

  assign o_in_ready    = !i_reset && !w_full && !w_in_stall;
  assign o_out_valid   = !w_empty && w_head_ripe && !w_out_stall;
  assign o_out_data    = r_data[r_rd_ptr];
  assign o_occupancy   = r_count;
  assign o_stall_count = r_stall_cnt;

  assign w_push = i_in_valid && o_in_ready;
  assign w_pop  = o_out_valid && i_out_ready;

  always_comb begin
    w_ripe_next = w_ripe_now;
    if (w_pop)  w_ripe_next[r_rd_ptr] = 1'b0;
    if (w_push) w_ripe_next[r_wr_ptr] = 1'b0;
  end

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_data[r_wr_ptr]  <= i_in_data;
      r_stamp[r_wr_ptr] <= r_now;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_now       <= '0;
      r_ripe      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_now  <= r_now + TW'(1);
      r_ripe <= w_ripe_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (!w_empty && w_head_ripe && w_out_stall && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CntWidth'(1);
    end
  end

endmodule

// File: tb/tb_dram_throttle_channel.sv
module tb_dram_throttle_channel;
  localparam int unsigned W  = 64;
  localparam int unsigned D  = 16;
  localparam int unsigned LW = 6;
  localparam int unsigned CW = 32;
  localparam logic [15:0] S_IN  = 16'hACE1;
  localparam logic [15:0] S_OUT = 16'h1D87;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [6:0]    in_bw, out_bw;
  logic [LW-1:0] lat;
  logic [W-1:0]  in_data, out_data;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [4:0]    occ;
  logic [CW-1:0] stall_cnt;

  dram_throttle_channel #(
    .Width(W), .Depth(D), .LatWidth(LW),
    .SeedIn(S_IN), .SeedOut(S_OUT), .CntWidth(CW)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_mode          (mode),
    .i_in_bandwidth  (in_bw),
    .i_out_bandwidth (out_bw),
    .i_latency       (lat),
    .i_in_data       (in_data),
    .i_in_valid      (in_valid),
    .o_in_ready      (in_ready),
    .o_out_data      (out_data),
    .o_out_valid     (out_valid),
    .i_out_ready     (out_ready),
    .o_occupancy     (occ),
    .o_stall_count   (stall_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue of beats tagged with their accept cycle.
  typedef struct {
    logic [W-1:0] data;
    longint       acc;
    bit           ripe;
  } ent_t;

  ent_t          q[$];
  logic [15:0]   m_lin, m_lout;
  logic [CW-1:0] m_sc;
  longint        mcyc = 0;
  bit            m_push = 1'b0;
  int            n_chk = 0, n_fail = 0;
  int            pops = 0;
  bit            duty_en = 1'b0;
  int            bw_cyc = 0, in_free = 0, out_free = 0;

  function automatic logic [15:0] m_step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic int m_pct(input logic [15:0] x);
    return (int'(x & 16'h007F) * 100) / 128;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  int c_lat;
  bit c_ist, c_ost, c_hr, c_ev, c_er;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_lin  = S_IN;
      m_lout = S_OUT;
      m_sc   = '0;
      m_push = 1'b0;
    end else begin
      c_lat = (mode == 2'b00 || lat == '0) ? 1 : int'(lat);
      c_ist = mode[1] && (m_pct(m_lin)  >= int'(in_bw));
      c_ost = mode[1] && (m_pct(m_lout) >= int'(out_bw));
      c_hr  = 1'b0;
      if (q.size() > 0) c_hr = q[0].ripe || ((mcyc - q[0].acc) >= longint'(c_lat));
      c_ev  = c_hr && !c_ost;
      c_er  = (q.size() < int'(D)) && !c_ist;

      check("in_ready",    in_ready,  c_er);
      check("out_valid",   out_valid, c_ev);
      check("occupancy",   occ,       q.size());
      check("stall_count", stall_cnt, m_sc);
      if (q.size() > 0) check("out_data", out_data, q[0].data);

      if (duty_en) begin
        bw_cyc++;
        if (!c_ist) in_free++;
        if (!c_ost) out_free++;
      end
      if (c_hr && c_ost && m_sc != '1) m_sc++;
      foreach (q[i]) if ((mcyc - q[i].acc) >= longint'(c_lat)) q[i].ripe = 1'b1;
      if (c_ev && out_ready) begin
        void'(q.pop_front());
        pops++;
      end
      m_push = in_valid && c_er;
      if (m_push) q.push_back('{in_data, mcyc, 1'b0});
      m_lin  = m_step(m_lin);
      m_lout = m_step(m_lout);
      mcyc++;
    end
  end

  // Seeds give accept-side percents 75, 87, 43, 21: with 50% duty the first
  // four post-reset cycles are stall, stall, ready, ready.
  task automatic lfsr_start(input string tag);
    logic [3:0] exp_rdy;
    exp_rdy = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check({tag, "_lfsr_ready"}, in_ready, exp_rdy[i]);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, nv, maxo, p0, sent, guard, dpi, dpo;

    check("pin_pct_seed",  m_pct(S_IN), 75);
    check("pin_pct_step1", m_pct(m_step(S_IN)), 87);
    check("pin_pct_step2", m_pct(m_step(m_step(S_IN))), 43);

    rst = 1'b1; mode = 2'b10; in_bw = 7'd50; out_bw = 7'd50; lat = 6'd5;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_occ",       occ,       0);
    check("rst_stall",     stall_cnt, 0);
    @(posedge clk); #1 rst = 1'b0;
    lfsr_start("init");

    // Single beat, latency 5
    @(posedge clk); #1;
    mode = 2'b01; lat = 6'd5; in_data = 64'h1234; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check("t1_latency", n, 5);
    check("t1_data", out_data, 64'h1234);
    check("t1_stall", stall_cnt, 0);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back, latency 0
    lat = 6'd0; maxo = 0; p0 = pops;
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_data  = 64'hA00 + 64'(i);
      @(negedge clk);
      if (int'(occ) > maxo) maxo = int'(occ);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (int'(occ) > maxo) maxo = int'(occ);
    end
    check("t2_peak_occ", maxo, 1);
    check("t2_pops", pops - p0, 32);

    // Fill, hold past timestamp wrap, drain
    @(posedge clk); #1;
    out_ready = 1'b0; lat = 6'd1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 64'hB000 + 64'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("t3_occ_full", occ, 16);
    check("t3_ready_full", in_ready, 0);
    repeat (200) @(posedge clk);
    #1 out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (out_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("t3_drain_run", n, 16);
    check("t3_empty", occ, 0);

    // Random traffic at 50/50 duty
    @(posedge clk); #1;
    mode = 2'b10; in_bw = 7'd50; out_bw = 7'd50; lat = 6'd3;
    p0 = pops; sent = 0; guard = 0;
    bw_cyc = 0; in_free = 0; out_free = 0; duty_en = 1'b1;
    in_valid = 1'b1; in_data = {$urandom, $urandom};
    while ((sent < 10000 || q.size() > 0) && guard < 60000) begin
      @(posedge clk); #1;
      guard++;
      if (m_push) sent++;
      in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 9) != 0);
    end
    duty_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("t4_no_timeout", guard < 60000, 1);
    check("t4_pops", pops - p0, 10000);
    dpi = (bw_cyc > 0) ? (in_free * 100) / bw_cyc : 0;
    dpo = (bw_cyc > 0) ? (out_free * 100) / bw_cyc : 0;
    check("t4_accept_duty_45_55", (dpi >= 45 && dpi <= 55), 1);
    check("t4_issue_duty_45_55",  (dpo >= 45 && dpo <= 55), 1);

    // Reset mid-burst with 7 beats stored
    @(posedge clk); #1;
    mode = 2'b01; lat = 6'd1; out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 64'hC000 + 64'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("t6_occ7", occ, 7);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    check("t6_rst_occ",       occ,       0);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_in_ready",  in_ready,  0);
    check("t6_rst_stall",     stall_cnt, 0);
    mode = 2'b10; in_bw = 7'd50; out_bw = 7'd50; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    lfsr_start("post_reset");

    // Issue duty 0 with three ripe beats, then 100
    @(posedge clk); #1;
    in_bw = 7'd100; out_bw = 7'd0; lat = 6'd2;
    in_valid = 1'b1; in_data = 64'hD001;
    @(posedge clk); #1 in_data = 64'hD002;
    @(posedge clk); #1 in_data = 64'hD003;
    @(posedge clk); #1 in_valid = 1'b0;
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) nv++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t5_no_valid", nv, 0);
    check("t5_stall_cnt", stall_cnt, 11);
    check("t5_occ", occ, 3);
    @(posedge clk); #1 out_bw = 7'd100;
    n = 0;
    @(negedge clk);
    while (out_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("t5_release_run", n, 3);
    check("t5_stall_final", stall_cnt, 12);
    check("t5_empty", occ, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
